// File: rtl/master_port_requester.sv
// Master-side crossbar requester: decodes the target slave, runs the request/lock
// handshake with that slave's arbiter, forwards the transaction and returns the response.
//
// state  | meaning
// IDLE   | no slave owned, waiting for a master transaction
// REQ    | requesting r_Sel arbiter, waiting for grant
// ACTIVE | granted and locked, transaction forwarded to slave r_Sel
// HOLD   | locked sequence: slave r_Sel kept between transactions
// ERR    | one-cycle decode-error response
module master_port_requester #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {32'hF000_0000, 32'hF000_0000}
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic                             i_M_Valid,
  input  logic                             i_M_Lock,
  input  logic                             i_M_Write,
  input  logic [ADDR_WIDTH-1:0]            i_M_Addr,
  input  logic [DATA_WIDTH-1:0]            i_M_WData,
  input  logic [DATA_WIDTH/8-1:0]          i_M_WStrb,
  output logic                             o_M_Ready,
  output logic                             o_M_Err,
  output logic [DATA_WIDTH-1:0]            o_M_RData,
  output logic [NUM_SLAVES-1:0]            o_Req,
  output logic [NUM_SLAVES-1:0]            o_Lock,
  input  logic [NUM_SLAVES-1:0]            i_Gnt,
  output logic [NUM_SLAVES-1:0]            o_S_Valid,
  output logic                             o_S_Write,
  output logic [ADDR_WIDTH-1:0]            o_S_Addr,
  output logic [DATA_WIDTH-1:0]            o_S_WData,
  output logic [DATA_WIDTH/8-1:0]          o_S_WStrb,
  input  logic [NUM_SLAVES-1:0]            i_S_Ready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_S_RData
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACTIVE, S_HOLD, S_ERR} state_t;

  state_t                  r_State;
  logic [SEL_W-1:0]        r_Sel;
  logic [NUM_SLAVES-1:0]   r_Req;
  logic [NUM_SLAVES-1:0]   r_Lock;

  logic                    w_Hit;
  logic [SEL_W-1:0]        w_Dec_Sel;
  logic                    w_Gnt_Sel;
  logic                    w_Active;
  logic                    w_Done;
  logic [DATA_WIDTH-1:0]   w_RData_Sel;

  function automatic logic [NUM_SLAVES-1:0] one_hot(input logic [SEL_W-1:0] idx);
    one_hot = '0;
    one_hot[idx] = 1'b1;
  endfunction

  // Scan high to low so the lowest matching index wins on overlapping windows.
  always_comb begin
    w_Hit     = 1'b0;
    w_Dec_Sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_M_Addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        w_Hit     = 1'b1;
        w_Dec_Sel = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_RData_Sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (SEL_W'(i) == r_Sel) w_RData_Sel = i_S_RData[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_Gnt_Sel = i_Gnt[r_Sel];
  assign w_Active  = (r_State == S_ACTIVE);
  assign w_Done    = w_Active & i_S_Ready[r_Sel] & w_Gnt_Sel;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= S_IDLE;
      r_Sel   <= '0;
      r_Req   <= '0;
      r_Lock  <= '0;
    end else begin
      case (r_State)
        S_IDLE: begin
          if (i_M_Valid) begin
            if (w_Hit) begin
              r_State <= S_REQ;
              r_Sel   <= w_Dec_Sel;
              r_Req   <= one_hot(w_Dec_Sel);
              r_Lock  <= '0;
            end else begin
              r_State <= S_ERR;
            end
          end
        end
        S_REQ: begin
          if (w_Gnt_Sel) begin
            r_State <= S_ACTIVE;
            r_Lock  <= one_hot(r_Sel);
          end
        end
        S_ACTIVE: begin
          if (w_Done) begin
            if (i_M_Lock) begin
              r_State <= S_HOLD;
            end else begin
              r_State <= S_IDLE;
              r_Req   <= '0;
              r_Lock  <= '0;
            end
          end
        end
        S_HOLD: begin
          if (i_M_Valid) begin
            if (!w_Hit) begin
              r_State <= S_ERR;
              r_Req   <= '0;
              r_Lock  <= '0;
            end else if (w_Dec_Sel == r_Sel) begin
              r_State <= S_ACTIVE;
            end else begin
              // Switching slaves: old req/lock drop on the same edge the new request rises.
              r_State <= S_REQ;
              r_Sel   <= w_Dec_Sel;
              r_Req   <= one_hot(w_Dec_Sel);
              r_Lock  <= '0;
            end
          end else if (!i_M_Lock) begin
            r_State <= S_IDLE;
            r_Req   <= '0;
            r_Lock  <= '0;
          end
        end
        S_ERR: begin
          r_State <= S_IDLE;
        end
        default: begin
          r_State <= S_IDLE;
          r_Req   <= '0;
          r_Lock  <= '0;
        end
      endcase
    end
  end

  assign o_Req     = r_Req;
  assign o_Lock    = r_Lock;
  assign o_S_Valid = (w_Active && i_M_Valid && w_Gnt_Sel) ? one_hot(r_Sel) : '0;
  assign o_M_Ready = w_Done | (r_State == S_ERR);
  assign o_M_Err   = (r_State == S_ERR);
  assign o_M_RData = w_Active ? w_RData_Sel : '0;

  assign o_S_Write = i_M_Write;
  assign o_S_Addr  = i_M_Addr;
  assign o_S_WData = i_M_WData;
  assign o_S_WStrb = i_M_WStrb;

endmodule

// File: tb/tb_master_port_requester.sv
// Directed bench for master_port_requester: one task per scenario, inline checks,
// expected values worked out by hand from the cycle-level protocol.
module tb_master_port_requester;

  logic        r_Clk = 1'b0;
  logic        r_Rst = 1'b0;
  logic        r_M_Valid = 1'b0;
  logic        r_M_Lock = 1'b0;
  logic        r_M_Write = 1'b0;
  logic [31:0] r_M_Addr = '0;
  logic [31:0] r_M_WData = '0;
  logic [3:0]  r_M_WStrb = '0;
  logic [1:0]  r_Gnt = '0;
  logic [1:0]  r_S_Ready = '0;
  logic [63:0] r_S_RData = '0;

  logic        w_M_Ready;
  logic        w_M_Err;
  logic [31:0] w_M_RData;
  logic [1:0]  w_Req;
  logic [1:0]  w_Lock;
  logic [1:0]  w_S_Valid;
  logic        w_S_Write;
  logic [31:0] w_S_Addr;
  logic [31:0] w_S_WData;
  logic [3:0]  w_S_WStrb;

  int errors = 0;
  int checks = 0;

  master_port_requester dut (
    .i_Clk     (r_Clk),
    .i_Rst     (r_Rst),
    .i_M_Valid (r_M_Valid),
    .i_M_Lock  (r_M_Lock),
    .i_M_Write (r_M_Write),
    .i_M_Addr  (r_M_Addr),
    .i_M_WData (r_M_WData),
    .i_M_WStrb (r_M_WStrb),
    .o_M_Ready (w_M_Ready),
    .o_M_Err   (w_M_Err),
    .o_M_RData (w_M_RData),
    .o_Req     (w_Req),
    .o_Lock    (w_Lock),
    .i_Gnt     (r_Gnt),
    .o_S_Valid (w_S_Valid),
    .o_S_Write (w_S_Write),
    .o_S_Addr  (w_S_Addr),
    .o_S_WData (w_S_WData),
    .o_S_WStrb (w_S_WStrb),
    .i_S_Ready (r_S_Ready),
    .i_S_RData (r_S_RData)
  );

  always #5 r_Clk = ~r_Clk;

  task automatic cyc();
    @(posedge r_Clk);
    #1;
  endtask

  task automatic test_reset();
    #2 r_Rst = 1'b1;
    r_M_Addr = 32'hABCD_0123; r_M_WData = 32'h0F0F_1234; r_M_WStrb = 4'b1010; r_M_Write = 1'b1;
    #1;
    checks++; if (w_Req !== 2'b00) begin errors++; $display("FAIL reset_req got=%b exp=00", w_Req); end
    checks++; if (w_Lock !== 2'b00) begin errors++; $display("FAIL reset_lock got=%b exp=00", w_Lock); end
    checks++; if (w_M_Ready !== 1'b0 || w_M_Err !== 1'b0) begin errors++; $display("FAIL reset_ready_err got=%b%b exp=00", w_M_Ready, w_M_Err); end
    checks++; if (w_M_RData !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", w_M_RData); end
    checks++; if (w_S_Addr !== 32'hABCD_0123 || w_S_WData !== 32'h0F0F_1234 || w_S_WStrb !== 4'b1010 || w_S_Write !== 1'b1) begin
      errors++; $display("FAIL reset_passthru got=%h/%h/%b/%b exp=abcd0123/0f0f1234/1010/1", w_S_Addr, w_S_WData, w_S_WStrb, w_S_Write); end
    cyc(); cyc();
    r_Rst = 1'b0; r_M_Write = 1'b0;
  endtask

  // Read of slave 1, grant two cycles after request, ready one cycle after valid.
  task automatic test_read();
    cyc(); r_M_Valid = 1'b1; r_M_Addr = 32'h1000_0004; r_M_Lock = 1'b0; r_S_RData = {32'hDEAD_BEEF, 32'h1111_1111}; #1;
    checks++; if (w_Req !== 2'b00) begin errors++; $display("FAIL read_c0_req got=%b exp=00", w_Req); end
    cyc(); #1;
    checks++; if (w_Req !== 2'b10 || w_Lock !== 2'b00) begin errors++; $display("FAIL read_c1_req_lock got=%b/%b exp=10/00", w_Req, w_Lock); end
    checks++; if (w_S_Valid !== 2'b00 || w_M_RData !== 32'h0) begin errors++; $display("FAIL read_c1_quiet got=%b/%h exp=00/0", w_S_Valid, w_M_RData); end
    cyc(); #1;
    checks++; if (w_Req !== 2'b10) begin errors++; $display("FAIL read_c2_req got=%b exp=10", w_Req); end
    cyc(); r_Gnt = 2'b10; #1;
    checks++; if (w_S_Valid !== 2'b00) begin errors++; $display("FAIL read_c3_svalid got=%b exp=00", w_S_Valid); end
    cyc(); #1;
    checks++; if (w_S_Valid !== 2'b10 || w_Lock !== 2'b10 || w_Req !== 2'b10) begin
      errors++; $display("FAIL read_active got sv=%b lk=%b rq=%b exp 10/10/10", w_S_Valid, w_Lock, w_Req); end
    checks++; if (w_M_Ready !== 1'b0) begin errors++; $display("FAIL read_early_ready got=%b exp=0", w_M_Ready); end
    cyc(); r_S_Ready = 2'b10; #1;
    checks++; if (w_M_Ready !== 1'b1 || w_M_Err !== 1'b0 || w_M_RData !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_done got rdy=%b err=%b rd=%h exp 1/0/deadbeef", w_M_Ready, w_M_Err, w_M_RData); end
    cyc(); r_M_Valid = 1'b0; r_S_Ready = 2'b00; r_Gnt = 2'b00; #1;
    checks++; if (w_Req !== 2'b00 || w_Lock !== 2'b00 || w_M_Ready !== 1'b0) begin
      errors++; $display("FAIL read_idle got rq=%b lk=%b rdy=%b exp 00/00/0", w_Req, w_Lock, w_M_Ready); end
  endtask

  task automatic test_error();
    cyc(); r_M_Valid = 1'b1; r_M_Addr = 32'h2000_0000; r_S_RData = {32'h7777_7777, 32'h8888_8888}; #1;
    checks++; if (w_M_Ready !== 1'b0 || w_Req !== 2'b00) begin errors++; $display("FAIL err_c0 got rdy=%b rq=%b exp 0/00", w_M_Ready, w_Req); end
    cyc(); #1;
    checks++; if (w_M_Ready !== 1'b1 || w_M_Err !== 1'b1 || w_M_RData !== 32'h0 || w_Req !== 2'b00) begin
      errors++; $display("FAIL err_resp got rdy=%b err=%b rd=%h rq=%b exp 1/1/0/00", w_M_Ready, w_M_Err, w_M_RData, w_Req); end
    cyc(); r_M_Valid = 1'b0; #1;
    checks++; if (w_M_Ready !== 1'b0 || w_M_Err !== 1'b0 || w_Req !== 2'b00) begin
      errors++; $display("FAIL err_after got rdy=%b err=%b rq=%b exp 0/0/00", w_M_Ready, w_M_Err, w_Req); end
  endtask

  task automatic test_locked_same();
    cyc(); r_M_Valid = 1'b1; r_M_Lock = 1'b1; r_M_Write = 1'b1; r_M_Addr = 32'h0000_0010; r_M_WData = 32'hA5A5_0001; #1;
    cyc(); r_Gnt = 2'b01; #1;
    checks++; if (w_Req !== 2'b01) begin errors++; $display("FAIL lk_req got=%b exp=01", w_Req); end
    cyc(); r_S_Ready = 2'b01; #1;
    checks++; if (w_S_Valid !== 2'b01 || w_M_Ready !== 1'b1 || w_S_WData !== 32'hA5A5_0001) begin
      errors++; $display("FAIL lk_write got sv=%b rdy=%b wd=%h exp 01/1/a5a50001", w_S_Valid, w_M_Ready, w_S_WData); end
    cyc(); r_S_Ready = 2'b00; r_M_Write = 1'b0; r_M_Addr = 32'h0000_0020; r_S_RData = {32'h0, 32'h1234_5678}; #1;
    checks++; if (w_Req !== 2'b01 || w_Lock !== 2'b01 || w_S_Valid !== 2'b00 || w_M_Ready !== 1'b0) begin
      errors++; $display("FAIL lk_hold got rq=%b lk=%b sv=%b rdy=%b exp 01/01/00/0", w_Req, w_Lock, w_S_Valid, w_M_Ready); end
    cyc(); r_S_Ready = 2'b01; #1;
    checks++; if (w_S_Valid !== 2'b01 || w_Req !== 2'b01 || w_M_Ready !== 1'b1 || w_M_RData !== 32'h1234_5678) begin
      errors++; $display("FAIL lk_read got sv=%b rq=%b rdy=%b rd=%h exp 01/01/1/12345678", w_S_Valid, w_Req, w_M_Ready, w_M_RData); end
    cyc(); r_S_Ready = 2'b00; r_M_Valid = 1'b0; r_M_Lock = 1'b0; #1;
    checks++; if (w_Req !== 2'b01 || w_Lock !== 2'b01 || w_M_RData !== 32'h0) begin
      errors++; $display("FAIL lk_hold2 got rq=%b lk=%b rd=%h exp 01/01/0", w_Req, w_Lock, w_M_RData); end
    cyc(); r_Gnt = 2'b00; #1;
    checks++; if (w_Req !== 2'b00 || w_Lock !== 2'b00) begin errors++; $display("FAIL lk_unlock got rq=%b lk=%b exp 00/00", w_Req, w_Lock); end
  endtask

  task automatic test_switch();
    cyc(); r_M_Valid = 1'b1; r_M_Lock = 1'b1; r_M_Addr = 32'h0000_0000; #1;
    cyc(); r_Gnt = 2'b01; #1;
    cyc(); r_S_Ready = 2'b01; #1;
    checks++; if (w_M_Ready !== 1'b1) begin errors++; $display("FAIL sw_first got rdy=%b exp 1", w_M_Ready); end
    cyc(); r_S_Ready = 2'b00; r_M_Lock = 1'b0; r_M_Addr = 32'h1000_0000; r_S_RData = {32'hCAFE_F00D, 32'h0}; #1;
    checks++; if (w_Req !== 2'b01 || w_Lock !== 2'b01) begin errors++; $display("FAIL sw_hold got rq=%b lk=%b exp 01/01", w_Req, w_Lock); end
    cyc(); r_Gnt = 2'b00; #1;
    checks++; if (w_Req !== 2'b10 || w_Lock !== 2'b00 || w_S_Valid !== 2'b00) begin
      errors++; $display("FAIL sw_switch got rq=%b lk=%b sv=%b exp 10/00/00", w_Req, w_Lock, w_S_Valid); end
    cyc(); #1;
    checks++; if (w_Req !== 2'b10 || w_S_Valid !== 2'b00) begin errors++; $display("FAIL sw_wait got rq=%b sv=%b exp 10/00", w_Req, w_S_Valid); end
    r_Gnt = 2'b10;
    cyc(); r_S_Ready = 2'b10; #1;
    checks++; if (w_S_Valid !== 2'b10 || w_Lock !== 2'b10 || w_M_Ready !== 1'b1 || w_M_RData !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL sw_done got sv=%b lk=%b rdy=%b rd=%h exp 10/10/1/cafef00d", w_S_Valid, w_Lock, w_M_Ready, w_M_RData); end
    cyc(); r_M_Valid = 1'b0; r_S_Ready = 2'b00; r_Gnt = 2'b00; #1;
    checks++; if (w_Req !== 2'b00) begin errors++; $display("FAIL sw_idle got rq=%b exp 00", w_Req); end
  endtask

  task automatic test_grant_stall();
    int ready_count;
    ready_count = 0;
    cyc(); r_M_Valid = 1'b1; r_M_Addr = 32'h1000_0008; r_S_RData = {32'h5555_AAAA, 32'h0}; #1;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      checks++; if (w_Req !== 2'b10 || w_S_Valid !== 2'b00 || w_M_Ready !== 1'b0) begin
        errors++; $display("FAIL stall_req[%0d] got rq=%b sv=%b rdy=%b exp 10/00/0", i, w_Req, w_S_Valid, w_M_Ready); end
    end
    r_Gnt = 2'b10;
    cyc(); #1;
    checks++; if (w_S_Valid !== 2'b10) begin errors++; $display("FAIL stall_active got sv=%b exp 10", w_S_Valid); end
    for (int i = 0; i < 2; i++) begin
      cyc(); r_Gnt = 2'b00; r_S_Ready = 2'b10; #1;
      if (w_M_Ready === 1'b1) ready_count++;
      checks++; if (w_S_Valid !== 2'b00 || w_M_Ready !== 1'b0 || w_Req !== 2'b10 || w_Lock !== 2'b10) begin
        errors++; $display("FAIL stall_drop[%0d] got sv=%b rdy=%b rq=%b lk=%b exp 00/0/10/10", i, w_S_Valid, w_M_Ready, w_Req, w_Lock); end
    end
    cyc(); r_Gnt = 2'b10; #1;
    if (w_M_Ready === 1'b1) ready_count++;
    checks++; if (w_S_Valid !== 2'b10 || w_M_Ready !== 1'b1 || w_M_RData !== 32'h5555_AAAA) begin
      errors++; $display("FAIL stall_regrant got sv=%b rdy=%b rd=%h exp 10/1/5555aaaa", w_S_Valid, w_M_Ready, w_M_RData); end
    cyc(); r_M_Valid = 1'b0; r_Gnt = 2'b00; r_S_Ready = 2'b00; #1;
    if (w_M_Ready === 1'b1) ready_count++;
    checks++; if (ready_count != 1) begin errors++; $display("FAIL stall_pulses got=%0d exp=1", ready_count); end
  endtask

  task automatic test_reset_mid();
    cyc(); r_M_Valid = 1'b1; r_M_Lock = 1'b1; r_M_Addr = 32'h0000_0040; r_S_RData = {32'h0, 32'h9999_0000}; #1;
    cyc(); r_Gnt = 2'b01; #1;
    cyc(); r_S_Ready = 2'b01; #1;
    checks++; if (w_M_Ready !== 1'b1 || w_S_Valid !== 2'b01) begin errors++; $display("FAIL rst_pre got rdy=%b sv=%b exp 1/01", w_M_Ready, w_S_Valid); end
    #2 r_Rst = 1'b1; #1;
    checks++; if (w_Req !== 2'b00 || w_Lock !== 2'b00 || w_S_Valid !== 2'b00 || w_M_Ready !== 1'b0 || w_M_RData !== 32'h0) begin
      errors++; $display("FAIL rst_async got rq=%b lk=%b sv=%b rdy=%b rd=%h exp 00/00/00/0/0", w_Req, w_Lock, w_S_Valid, w_M_Ready, w_M_RData); end
    cyc();
    r_Rst = 1'b0; r_M_Valid = 1'b0; r_M_Lock = 1'b0; r_Gnt = 2'b00; r_S_Ready = 2'b00;
    cyc(); #1;
    checks++; if (w_Req !== 2'b00 || w_M_Ready !== 1'b0) begin errors++; $display("FAIL rst_idle got rq=%b rdy=%b exp 00/0", w_Req, w_M_Ready); end
    r_M_Valid = 1'b1; r_M_Addr = 32'h1000_0000;
    cyc(); #1;
    checks++; if (w_Req !== 2'b10 || w_Lock !== 2'b00) begin errors++; $display("FAIL rst_restart got rq=%b lk=%b exp 10/00", w_Req, w_Lock); end
    r_M_Valid = 1'b0;
    r_Rst = 1'b1; cyc(); r_Rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_error();
    test_locked_same();
    test_switch();
    test_grant_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/master_port_requester.md
# master_port_requester

Master-side requester for the XbarV1 crossbar: the initiator end of the per-slave arbitration handshake. It decodes each master transaction address to a target slave, drives that slave arbiter's request and lock lines, waits for grant, and forwards the transaction. It returns the slave's response, holding the slave across back-to-back locked transactions when the master asks for it. One instance per crossbar master.

## Interface
- NUM_SLAVES, 2, number of slave ports / arbiters served.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- SLAVE_BASE, {32'h1000_0000, 32'h0000_0000}, flattened NUM_SLAVES*ADDR_WIDTH base addresses; slave i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- SLAVE_MASK, {32'hF000_0000, 32'hF000_0000}, flattened decode masks, same layout.

Ports:
- i_Clk  in  1  clock; all state changes on its rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_M_Valid  in  1  master transaction valid; held with payload stable until o_M_Ready.
- i_M_Lock  in  1  keep the slave after this transaction.
- i_M_Write  in  1  1 = write, 0 = read.
- i_M_Addr  in  ADDR_WIDTH  address.
- i_M_WData  in  DATA_WIDTH  write data.
- i_M_WStrb  in  DATA_WIDTH/8  byte strobes.
- o_M_Ready  out  1  one-cycle completion pulse.
- o_M_Err  out  1  decode error, valid with o_M_Ready.
- o_M_RData  out  DATA_WIDTH  read data, valid with o_M_Ready.
- o_Req  out  NUM_SLAVES  one-hot request to slave arbiters.
- o_Lock  out  NUM_SLAVES  one-hot lock to slave arbiters.
- i_Gnt  in  NUM_SLAVES  this master's grant from each arbiter.
- o_S_Valid  out  NUM_SLAVES  one-hot transaction valid to slaves.
- o_S_Write, o_S_Addr, o_S_WData, o_S_WStrb  out  as master side  broadcast payload, passed through from i_M_*.
- i_S_Ready  in  NUM_SLAVES  per-slave completion.
- i_S_RData  in  NUM_SLAVES*DATA_WIDTH  flattened per-slave read data.

## Operation
- Decode: slave i hits when (i_M_Addr & MASK_i) == (BASE_i & MASK_i). Multiple hits resolve to the lowest index. The selected index is registered in r_Sel when leaving IDLE or HOLD.
- States: IDLE, REQ, ACTIVE, HOLD, ERR.
- IDLE: on i_M_Valid with a hit, latch r_Sel and go to REQ. With no hit, go to ERR.
- REQ: o_Req[r_Sel]=1, o_Lock=0. Go to ACTIVE when i_Gnt[r_Sel]=1.
- ACTIVE:
  - o_Req[r_Sel]=1 and o_Lock[r_Sel]=1.
  - o_S_Valid[r_Sel] = i_M_Valid & i_Gnt[r_Sel].
  - o_M_Ready = i_S_Ready[r_Sel] & i_Gnt[r_Sel], combinational.
  - o_M_RData = i_S_RData slice r_Sel.
  - On o_M_Ready: go to HOLD if i_M_Lock, else IDLE.
  - A dropped grant stalls o_S_Valid until regranted; the state does not change.
- HOLD: o_Req and o_Lock stay asserted for r_Sel.
  - If i_M_Lock=0 and i_M_Valid=0, go to IDLE.
  - On i_M_Valid with the same-slave hit, go to ACTIVE (no re-request).
  - On a different slave, go to REQ with the new r_Sel.
  - On no hit, go to ERR.
  - Old req/lock drop on the transition edge.
- ERR: o_M_Ready=1, o_M_Err=1, o_M_RData=0 for exactly one cycle, then IDLE. No o_Req asserted.
- o_S_Valid, o_Req and o_Lock are never asserted for more than one slave.
- o_M_Err=0 outside ERR. o_M_RData=0 outside ACTIVE.

## Timing
- Reset (async, immediate): state IDLE, r_Sel=0. All outputs 0 except the o_S_* payload pass-through.
- Fresh transaction: Valid at cycle 0 → o_Req at cycle 1 → grant at cycle k≥1 → ACTIVE at k+1, o_S_Valid at k+1 → o_M_Ready in the same cycle as i_S_Ready.
- Locked same-slave follow-on: Valid in HOLD → o_S_Valid one cycle later, no request gap.
- Error response: o_M_Ready one cycle after Valid.
- Reset mid-ACTIVE: all req/lock/valid lines drop asynchronously. The master transaction is abandoned and no o_M_Ready is issued.
- Valid deasserted in REQ (protocol violation): keep requesting, no forward progress required.

## Test plan
- Read 0x1000_0004, grant 2 cycles after o_Req, slave 1 ready 1 cycle after o_S_Valid, RData 0xDEAD_BEEF → o_Req=2'b10 at cycle 1, o_Lock=2'b10 in ACTIVE, one o_M_Ready pulse, o_M_RData=0xDEAD_BEEF, back to IDLE with o_Req=0.
- Unmapped 0x2000_0000 → o_M_Ready=1, o_M_Err=1, RData=0 at cycle 1; o_Req never asserted.
- Locked write to 0x0000_0010 then locked read to 0x0000_0020 → o_Req[0]/o_Lock[0] stay high continuously, second o_S_Valid one cycle after Valid; unlock → IDLE.
- Locked access to slave 0 then access to 0x1000_0000 → o_Req switches 01→10 on one edge, never 11; waits for i_Gnt[1].
- Grant withheld 5 cycles in REQ, then dropped for 2 cycles mid-ACTIVE → o_S_Valid low while ungranted, completion after regrant, single o_M_Ready.
- Assert i_Rst mid-ACTIVE (async, between edges) → o_Req, o_Lock, o_S_Valid, o_M_Ready all 0 immediately; next Valid after release restarts from IDLE.
